// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC controller: request handshake, stall hold,
// redirect capture and misaligned-target trap.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC         = 32'h0000_3000,
  parameter int unsigned ADDR_ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC,
  input  logic [31:0] PCPlus4,
  output logic        IReq,
  input  logic        IAck,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic        FetchValid,
  output logic [31:0] FetchPC,
  output logic        AlignErr
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_HOLD,
    S_ERR
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_pend;
  logic [31:0] r_tgt;
  logic        r_errp;
  logic        r_fv;
  logic [31:0] r_fpc;
  logic        r_aerr;

  state_t      w_state_n;
  logic [31:0] w_pc_n;
  logic        w_pend_n;
  logic [31:0] w_tgt_n;
  logic        w_errp_n;
  logic        w_fv_n;
  logic [31:0] w_fpc_n;
  logic        w_aerr_n;
  logic        w_mis;
  logic        w_rd;

  assign w_mis = Redirect && (ADDR_ALIGN_CHECK != 0)
              && (RedirectTarget[1:0] != 2'b00);
  assign w_rd  = Redirect && !w_mis;

  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_pend_n  = r_pend;
    w_tgt_n   = r_tgt;
    w_errp_n  = r_errp;
    w_fv_n    = 1'b0;
    w_fpc_n   = r_fpc;
    w_aerr_n  = r_aerr | w_mis;
    unique case (r_state)
      S_BOOT: begin
        w_state_n = S_FETCH;
        if (w_mis)     w_state_n = S_ERR;
        else if (w_rd) w_pc_n    = RedirectTarget;
      end
      S_FETCH: begin
        // errp remembers a trapped target until the request is accepted
        if (w_mis) begin
          w_pend_n = 1'b0;
          w_errp_n = 1'b1;
        end else if (w_rd) begin
          w_pend_n = 1'b1;
          w_tgt_n  = RedirectTarget;
        end
        if (IAck) begin
          w_pend_n = 1'b0;
          w_errp_n = 1'b0;
          if (w_mis || r_errp) begin
            w_state_n = S_ERR;
          end else begin
            w_state_n = Stall ? S_HOLD : S_FETCH;
            if (w_rd) begin
              w_pc_n = RedirectTarget;
            end else if (r_pend) begin
              w_pc_n = r_tgt;
            end else begin
              w_pc_n  = PCPlus4;
              w_fv_n  = 1'b1;
              w_fpc_n = r_pc;
            end
          end
        end
      end
      S_HOLD: begin
        if (w_mis) begin
          w_state_n = S_ERR;
        end else begin
          if (w_rd)   w_pc_n    = RedirectTarget;
          if (!Stall) w_state_n = S_FETCH;
        end
      end
      S_ERR: begin
        w_state_n = S_ERR;
      end
      default: w_state_n = S_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_pend  <= 1'b0;
      r_tgt   <= 32'd0;
      r_errp  <= 1'b0;
      r_fv    <= 1'b0;
      r_fpc   <= 32'd0;
      r_aerr  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_pend  <= w_pend_n;
      r_tgt   <= w_tgt_n;
      r_errp  <= w_errp_n;
      r_fv    <= w_fv_n;
      r_fpc   <= w_fpc_n;
      r_aerr  <= w_aerr_n;
    end
  end

  assign PC         = r_pc;
  assign IReq       = (r_state == S_FETCH);
  assign FetchValid = r_fv;
  assign FetchPC    = r_fpc;
  assign AlignErr   = r_aerr;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl; reported fetches are
// matched against a queue of expected fetch addresses.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        IReq;
  logic        IAck;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        FetchValid;
  logic [31:0] FetchPC;
  logic        AlignErr;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // external PC+4 adder
  assign PCPlus4 = PC + 32'd4;

  pc_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .PC             (PC),
    .PCPlus4        (PCPlus4),
    .IReq           (IReq),
    .IAck           (IAck),
    .Stall          (Stall),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .FetchValid     (FetchValid),
    .FetchPC        (FetchPC),
    .AlignErr       (AlignErr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_fetch();
    logic [31:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("fvalid", {31'd0, FetchValid}, 32'd1);
      chk("fpc", FetchPC, e);
    end else begin
      chk("fvalid", {31'd0, FetchValid}, 32'd0);
    end
  endtask

  task automatic step(input logic        ack,
                      input logic        stl,
                      input logic        rd,
                      input logic [31:0] tgt,
                      input logic        push,
                      input logic [31:0] push_pc,
                      input logic [31:0] exp_pc,
                      input logic        exp_ireq,
                      input logic        exp_aerr);
    IAck           = ack;
    Stall          = stl;
    Redirect       = rd;
    RedirectTarget = tgt;
    if (push) exp_q.push_back(push_pc);
    @(posedge clk);
    #1;
    chk("pc", PC, exp_pc);
    chk("ireq", {31'd0, IReq}, {31'd0, exp_ireq});
    chk("aerr", {31'd0, AlignErr}, {31'd0, exp_aerr});
    check_fetch();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    Redirect = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_pc", PC, 32'h0000_3000);
    chk("rst_ireq", {31'd0, IReq}, 32'd0);
    chk("rst_fv", {31'd0, FetchValid}, 32'd0);
    chk("rst_fpc", FetchPC, 32'd0);
    chk("rst_aerr", {31'd0, AlignErr}, 32'd0);
    exp_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    IAck           = 1'b0;
    Stall          = 1'b0;
    Redirect       = 1'b0;
    RedirectTarget = 32'd0;
    @(posedge clk);
    do_reset();

    // sequential stream
    step(1, 0, 0, 0, 0, 0,            32'h3000, 1, 0);
    step(1, 0, 0, 0, 1, 32'h3000,     32'h3004, 1, 0);
    step(1, 0, 0, 0, 1, 32'h3004,     32'h3008, 1, 0);
    // wait with stall: request stays up, then HOLD
    step(0, 1, 0, 0, 0, 0,            32'h3008, 1, 0);
    step(0, 1, 0, 0, 0, 0,            32'h3008, 1, 0);
    step(0, 1, 0, 0, 0, 0,            32'h3008, 1, 0);
    step(1, 1, 0, 0, 1, 32'h3008,     32'h300C, 0, 0);
    step(0, 1, 0, 0, 0, 0,            32'h300C, 0, 0);
    step(0, 0, 0, 0, 0, 0,            32'h300C, 1, 0);
    // pending redirect, latest wins
    step(0, 0, 1, 32'h3100, 0, 0,     32'h300C, 1, 0);
    step(0, 0, 1, 32'h3200, 0, 0,     32'h300C, 1, 0);
    step(1, 0, 0, 0, 0, 0,            32'h3200, 1, 0);
    // redirect coincident with accept
    step(1, 0, 1, 32'h3300, 0, 0,     32'h3300, 1, 0);
    step(1, 0, 0, 0, 1, 32'h3300,     32'h3304, 1, 0);
    // misaligned redirect in HOLD
    step(1, 1, 0, 0, 1, 32'h3304,     32'h3308, 0, 0);
    step(0, 1, 1, 32'h3102, 0, 0,     32'h3308, 0, 1);
    step(0, 0, 0, 0, 0, 0,            32'h3308, 0, 1);
    step(1, 0, 1, 32'h3400, 0, 0,     32'h3308, 0, 1);
    do_reset();

    // reset while a request is outstanding
    step(0, 0, 0, 0, 0, 0,            32'h3000, 1, 0);
    step(0, 0, 0, 0, 0, 0,            32'h3000, 1, 0);
    IAck = 1'b1;
    do_reset();
    // wrap through redirect issued in BOOT
    step(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 0);
    step(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0000_0000, 1, 0);
    step(1, 0, 0, 0, 1, 32'h0,         32'h0000_0004, 1, 0);
    // misaligned while waiting in FETCH, trap on accept
    step(0, 0, 1, 32'h0000_0005, 0, 0, 32'h0000_0004, 1, 1);
    step(1, 0, 0, 0, 0, 0,             32'h0000_0004, 0, 1);
    step(1, 0, 0, 0, 0, 0,             32'h0000_0004, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
